aes_ctr_core: RTL

// Counter datapath for AES CTR mode. Holds the 128-bit counter, loads it from software IV

---
 rtl/aes_ctr_core_pkg.sv | 26 ++
 rtl/aes_ctr_core_if.sv | 21 ++
 rtl/aes_ctr_fsm.sv | 87 ++++++++
 rtl/aes_ctr_core.sv | 97 +++++++++
 4 files changed

// File: rtl/aes_ctr_core_pkg.sv
// Shared parameters, FSM state encoding and byte-order helper for the AES CTR counter.
package aes_ctr_core_pkg;

    localparam int unsigned CtrWidth      = 128;
    localparam int unsigned SliceSizeCtr  = 16;
    localparam int unsigned NumSlicesCtr  = CtrWidth / SliceSizeCtr;
    localparam int unsigned SliceIdxWidth = $clog2(NumSlicesCtr);
    localparam int unsigned IvWeWidth     = 4;
    localparam int unsigned SlicesPerWord = NumSlicesCtr / IvWeWidth;

    typedef enum logic [1:0] {
        CTR_IDLE  = 2'b00,
        CTR_INCR  = 2'b01,
        CTR_ERROR = 2'b10
    } aes_ctr_e;

    // Port order (byte 0 = MSB at bits [7:0]) <-> integer order; pure wiring.
    function automatic logic [CtrWidth-1:0] aes_ctr_bswap(input logic [CtrWidth-1:0] x);
        logic [CtrWidth-1:0] y;
        for (int unsigned b = 0; b < CtrWidth / 8; b++) begin
            y[8*b +: 8] = x[CtrWidth - 8 - 8*b +: 8];
        end
        return y;
    endfunction

endpackage

// File: rtl/aes_ctr_core_if.sv
// Software-facing IV load / increment handshake and counter output bundle.
interface aes_ctr_core_if;

    logic [aes_ctr_core_pkg::CtrWidth-1:0]     iv;
    logic [aes_ctr_core_pkg::IvWeWidth-1:0]    iv_we;
    logic                                      incr_req;
    logic                                      incr_ack;
    logic [aes_ctr_core_pkg::CtrWidth-1:0]     ctr;
    logic [aes_ctr_core_pkg::NumSlicesCtr-1:0] ctr_we;

    modport master (
        output iv, iv_we, incr_req,
        input  incr_ack, ctr, ctr_we
    );

    modport slave (
        input  iv, iv_we, incr_req,
        output incr_ack, ctr, ctr_we
    );

endinterface

// File: rtl/aes_ctr_fsm.sv
// Slice-serial +1 engine: walks all counter slices LSB first, propagating the carry.
module aes_ctr_fsm
    import aes_ctr_core_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     incr_i,
    output logic                     ready_o,
    input  logic                     incr_err_i,
    output logic                     alert_o,
    output logic [SliceIdxWidth-1:0] ctr_slice_idx_o,
    input  logic [SliceSizeCtr-1:0]  ctr_slice_i,
    output logic [SliceSizeCtr-1:0]  ctr_slice_c_o,
    output logic                     ctr_we_o
);

    localparam int unsigned SumWidth = SliceSizeCtr + 1;
    localparam logic [SliceIdxWidth-1:0] LastIdx = SliceIdxWidth'(NumSlicesCtr - 1);

    aes_ctr_e                 state_q, state_d;
    logic [SliceIdxWidth-1:0] idx_q, idx_d;
    logic                     carry_q, carry_d;
    logic                     ready_q, ready_d;
    logic                     alert_q, alert_d;
    logic                     we_q, we_d;
    logic [SumWidth-1:0]      sum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CTR_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ready_q <= 1'b1;
            alert_q <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            ready_q <= ready_d;
            alert_q <= alert_d;
            we_q    <= we_d;
        end
    end

    // Flag outputs are derived from the next state so they are registered with it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum     = SumWidth'(ctr_slice_i) + SumWidth'(carry_q);

        unique case (state_q)
            CTR_IDLE: begin
                if (incr_i) begin
                    state_d = CTR_INCR;
                    idx_d   = '0;
                    carry_d = 1'b1;
                end
            end
            CTR_INCR: begin
                carry_d = sum[SliceSizeCtr];
                idx_d   = idx_q + SliceIdxWidth'(1);
                if (idx_q == LastIdx) begin
                    state_d = CTR_IDLE;
                end
            end
            CTR_ERROR: state_d = CTR_ERROR;
            default:   state_d = CTR_ERROR;
        endcase

        if (incr_err_i) begin
            state_d = CTR_ERROR;
        end

        ready_d = (state_d == CTR_IDLE);
        we_d    = (state_d == CTR_INCR);
        alert_d = (state_d == CTR_ERROR);
    end

    assign ready_o         = ready_q;
    assign alert_o         = alert_q;
    assign ctr_we_o        = we_q;
    assign ctr_slice_idx_o = idx_q;
    assign ctr_slice_c_o   = sum[SliceSizeCtr-1:0];

endmodule

// File: rtl/aes_ctr_core.sv
// AES CTR counter datapath: IV load, slice mux/write-back around aes_ctr_fsm,
// request/ack handshake and sticky fatal alert.
module aes_ctr_core
    import aes_ctr_core_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    aes_ctr_core_if.slave  ctr_if,
    input  logic           err_i,
    output logic           alert_o
);

    logic [NumSlicesCtr-1:0][SliceSizeCtr-1:0] ctr_q, ctr_d;
    logic [NumSlicesCtr-1:0]                   ctr_we_q, ctr_we_d;
    logic                                      busy_q, busy_d;
    logic                                      ack_q, ack_d;
    logic                                      alert_q, alert_d;

    logic [CtrWidth-1:0]      iv_int;
    logic                     fsm_incr, fsm_ready, fsm_incr_err, fsm_alert, fsm_we;
    logic [SliceIdxWidth-1:0] fsm_idx;
    logic [SliceSizeCtr-1:0]  fsm_slice_rd, fsm_slice_wr;
    logic                     load_en, wr_en, last_slice;

    assign iv_int       = aes_ctr_bswap(ctr_if.iv);
    assign fsm_slice_rd = ctr_q[fsm_idx];

    // An IV write in the same cycle takes priority; the request simply waits.
    assign fsm_incr = ctr_if.incr_req & fsm_ready & ~ack_q & ~(|ctr_if.iv_we)
                    & ~alert_q & ~err_i;

    // A slice write the core never asked for is treated as a fatal integrity fault.
    assign fsm_incr_err = err_i | (fsm_we & ~busy_q);

    assign load_en    = fsm_ready & ~alert_q & ~err_i;
    assign wr_en      = fsm_we & busy_q & ~alert_q & ~err_i;
    assign last_slice = (fsm_idx == SliceIdxWidth'(NumSlicesCtr - 1));

    aes_ctr_fsm u_aes_ctr_fsm (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .incr_i          (fsm_incr),
        .ready_o         (fsm_ready),
        .incr_err_i      (fsm_incr_err),
        .alert_o         (fsm_alert),
        .ctr_slice_idx_o (fsm_idx),
        .ctr_slice_i     (fsm_slice_rd),
        .ctr_slice_c_o   (fsm_slice_wr),
        .ctr_we_o        (fsm_we)
    );

    always_comb begin
        ctr_d = ctr_q;
        for (int unsigned i = 0; i < NumSlicesCtr; i++) begin
            if (load_en && ctr_if.iv_we[IvWeWidth - 1 - i / SlicesPerWord]) begin
                ctr_d[i] = iv_int[i * SliceSizeCtr +: SliceSizeCtr];
            end
        end
        if (wr_en) begin
            ctr_d[fsm_idx] = fsm_slice_wr;
        end

        ctr_we_d = wr_en ? (NumSlicesCtr'(1) << fsm_idx) : '0;
        ack_d    = wr_en & last_slice;

        busy_d = busy_q;
        if (fsm_incr) begin
            busy_d = 1'b1;
        end else if ((wr_en & last_slice) | alert_q | err_i) begin
            busy_d = 1'b0;
        end

        alert_d = alert_q | err_i | fsm_alert;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctr_q    <= '0;
            ctr_we_q <= '0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            alert_q  <= 1'b0;
        end else begin
            ctr_q    <= ctr_d;
            ctr_we_q <= ctr_we_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            alert_q  <= alert_d;
        end
    end

    assign ctr_if.ctr      = aes_ctr_bswap(ctr_q);
    assign ctr_if.ctr_we   = ctr_we_q;
    assign ctr_if.incr_ack = ack_q;
    assign alert_o         = alert_q;

endmodule
